// File: rtl/eco32f_fetch.sv
// eco32f instruction fetch: owns the PC, issues ibus reads and feeds decode,
// dropping responses to requests that a redirect has made stale.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | requesting the word at fetch_pc
// DISCARD | waiting out a stale request, response is dropped
// HOLD    | completed word parked in the hold buffer until stall drops
// HALT    | fetch fault seen, no requests until a redirect
module eco32f_fetch #(
    parameter logic [31:0] RESET_PC = 32'hE000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    input  logic        itlb_kmiss,
    input  logic        itlb_umiss,
    input  logic        itlb_invalid,
    input  logic        itlb_priv,
    output logic        ibus_req,
    output logic [31:0] ibus_adr,
    input  logic        ibus_ack,
    input  logic        ibus_err,
    input  logic [31:0] ibus_dat,
    output logic [31:0] id_insn,
    output logic [31:0] id_pc,
    output logic        id_exc_ibus_fault,
    output logic        id_exc_itlb_kmiss,
    output logic        id_exc_itlb_umiss,
    output logic        id_exc_itlb_invalid,
    output logic        id_exc_itlb_priv
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] fetch_pc;
    logic [31:0] disc_adr;
    logic        hb_valid;
    logic [31:0] hb_insn;
    logic [31:0] hb_pc;
    logic [4:0]  hb_flags;
    logic [4:0]  id_flags;

    logic        itlb_fault;
    logic        redirect;
    logic [31:0] redir_tgt;
    logic        ack_v;
    logic        err_v;
    logic        bus_done;
    logic        fetch_done;
    logic        fetch_fault;
    logic [31:0] fetch_insn;
    logic [4:0]  fetch_flags;
    logic        keep_outstanding;

    assign itlb_fault  = itlb_kmiss | itlb_umiss | itlb_invalid | itlb_priv;
    assign redirect    = exc_redirect | br_redirect;
    assign redir_tgt   = exc_redirect ? {exc_target[31:2], 2'b00}
                                      : {br_target[31:2], 2'b00};
    assign ack_v       = ibus_req & ibus_ack;
    assign err_v       = ibus_req & ibus_err;
    assign bus_done    = ack_v | err_v;
    assign fetch_done  = (state == S_FETCH) & (itlb_fault | bus_done);
    assign fetch_fault = itlb_fault | err_v;
    assign fetch_insn  = ack_v ? ibus_dat : 32'h0000_0000;
    assign fetch_flags = {err_v, itlb_kmiss, itlb_umiss, itlb_invalid, itlb_priv};
    // A redirect may not retract a live request; it is waited out in DISCARD.
    assign keep_outstanding = ((state == S_FETCH) || (state == S_DISCARD))
                              && ibus_req && !bus_done;

    assign {id_exc_ibus_fault, id_exc_itlb_kmiss, id_exc_itlb_umiss,
            id_exc_itlb_invalid, id_exc_itlb_priv} = id_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (redirect) begin
            state_nx = keep_outstanding ? S_DISCARD : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_done) begin
                        if (fetch_fault)   state_nx = S_HALT;
                        else if (if_stall) state_nx = S_HOLD;
                        else               state_nx = S_FETCH;
                    end
                end
                S_DISCARD: if (bus_done)  state_nx = S_FETCH;
                S_HOLD:    if (!if_stall) state_nx = S_FETCH;
                S_HALT:    state_nx = S_HALT;
                default:   state_nx = S_FETCH;
            endcase
        end
    end

    always_comb begin
        ibus_req = 1'b0;
        ibus_adr = fetch_pc;
        case (state)
            S_FETCH:   ibus_req = !rst && !itlb_fault;
            S_DISCARD: begin
                ibus_req = !rst;
                ibus_adr = disc_adr;
            end
            default:   ibus_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            disc_adr <= RESET_PC;
            hb_valid <= 1'b0;
            hb_insn  <= 32'h0000_0000;
            hb_pc    <= 32'h0000_0000;
            hb_flags <= 5'b0;
            id_insn  <= 32'h0000_0000;
            id_pc    <= 32'h0000_0000;
            id_flags <= 5'b0;
        end else if (redirect) begin
            fetch_pc <= redir_tgt;
            if (state == S_FETCH && keep_outstanding) begin
                disc_adr <= fetch_pc;
            end
            hb_valid <= 1'b0;
            id_insn  <= 32'h0000_0000;
            id_pc    <= redir_tgt;
            id_flags <= 5'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_done) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (if_stall) begin
                            hb_valid <= 1'b1;
                            hb_insn  <= fetch_insn;
                            hb_pc    <= fetch_pc;
                            hb_flags <= fetch_flags;
                        end else begin
                            id_insn  <= fetch_insn;
                            id_pc    <= fetch_pc;
                            id_flags <= fetch_flags;
                        end
                    end else if (!if_stall) begin
                        id_insn  <= 32'h0000_0000;
                        id_pc    <= fetch_pc;
                        id_flags <= 5'b0;
                    end
                end
                default: begin
                    if (!if_stall) begin
                        if (hb_valid && state != S_DISCARD) begin
                            id_insn  <= hb_insn;
                            id_pc    <= hb_pc;
                            id_flags <= hb_flags;
                            hb_valid <= 1'b0;
                        end else begin
                            id_insn  <= 32'h0000_0000;
                            id_pc    <= fetch_pc;
                            id_flags <= 5'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eco32f_fetch.sv
// Directed bench for eco32f_fetch: stimulus pushes expected bus requests and
// decode-side words into queues, a negedge monitor pops and compares them.
module tb_eco32f_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic        itlb_kmiss, itlb_umiss, itlb_invalid, itlb_priv;
    logic        ibus_req;
    logic [31:0] ibus_adr;
    logic        ibus_ack;
    logic        ibus_err;
    logic [31:0] ibus_dat;
    logic [31:0] id_insn;
    logic [31:0] id_pc;
    logic        id_exc_ibus_fault, id_exc_itlb_kmiss, id_exc_itlb_umiss;
    logic        id_exc_itlb_invalid, id_exc_itlb_priv;
    logic [4:0]  got_flags;

    always #5 clk = ~clk;

    eco32f_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_stall            (if_stall),
        .br_redirect         (br_redirect),
        .br_target           (br_target),
        .exc_redirect        (exc_redirect),
        .exc_target          (exc_target),
        .itlb_kmiss          (itlb_kmiss),
        .itlb_umiss          (itlb_umiss),
        .itlb_invalid        (itlb_invalid),
        .itlb_priv           (itlb_priv),
        .ibus_req            (ibus_req),
        .ibus_adr            (ibus_adr),
        .ibus_ack            (ibus_ack),
        .ibus_err            (ibus_err),
        .ibus_dat            (ibus_dat),
        .id_insn             (id_insn),
        .id_pc               (id_pc),
        .id_exc_ibus_fault   (id_exc_ibus_fault),
        .id_exc_itlb_kmiss   (id_exc_itlb_kmiss),
        .id_exc_itlb_umiss   (id_exc_itlb_umiss),
        .id_exc_itlb_invalid (id_exc_itlb_invalid),
        .id_exc_itlb_priv    (id_exc_itlb_priv)
    );

    assign got_flags = {id_exc_ibus_fault, id_exc_itlb_kmiss, id_exc_itlb_umiss,
                        id_exc_itlb_invalid, id_exc_itlb_priv};

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [4:0]  flags;
    } id_t;

    id_t         exp_id[$];
    logic [31:0] exp_req[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic        prev_stall = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_id(input logic [31:0] insn, input logic [31:0] pc, input logic [4:0] fl);
        id_t e;
        e.insn  = insn;
        e.pc    = pc;
        e.flags = fl;
        exp_id.push_back(e);
    endtask

    task automatic expect_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    // Monitor: every completed bus transfer and every freshly loaded
    // non-empty decode slot is matched against the scoreboard queues.
    initial begin
        id_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (ibus_req && (ibus_ack || ibus_err)) begin
                    if (exp_req.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL req_unexpected: got %h expected none", ibus_adr);
                    end else begin
                        chk("req_adr", ibus_adr, exp_req.pop_front());
                    end
                end
                if (!prev_stall && (id_insn != 32'h0 || got_flags != 5'b0)) begin
                    if (exp_id.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL id_unexpected: got insn %h pc %h expected none", id_insn, id_pc);
                    end else begin
                        e = exp_id.pop_front();
                        chk("id_insn", id_insn, e.insn);
                        chk("id_pc", id_pc, e.pc);
                        chk("id_flags", {27'b0, got_flags}, {27'b0, e.flags});
                    end
                end
            end
            prev_stall = if_stall;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_redirect  = 1'b0;
        exc_redirect = 1'b0;
        itlb_kmiss   = 1'b0;
        itlb_umiss   = 1'b0;
        itlb_invalid = 1'b0;
        itlb_priv    = 1'b0;
        ibus_ack     = 1'b0;
        ibus_err     = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        if_stall = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_id_reset(input string name);
        chk({name, "_insn"}, id_insn, 32'h0);
        chk({name, "_pc"}, id_pc, 32'h0);
        chk({name, "_flags"}, {27'b0, got_flags}, 32'h0);
    endtask

    logic [31:0] s1_dat[4];

    initial begin
        s1_dat = '{32'h11, 32'h22, 32'h33, 32'h44};
        br_target  = 32'h0;
        exc_target = 32'h0;
        ibus_dat   = 32'h0;
        rst        = 1'b1;
        if_stall   = 1'b0;
        idle();

        // reset values and sustained zero-wait fetch
        tick();
        tick();
        chk_id_reset("rst");
        chk("rst_req", {31'b0, ibus_req}, 32'h0);
        rst = 1'b0;
        #1;
        chk("first_req", {31'b0, ibus_req}, 32'h1);
        chk("first_adr", ibus_adr, 32'hE000_0000);
        for (int i = 0; i < 4; i++) begin
            ibus_ack = 1'b1;
            ibus_dat = s1_dat[i];
            expect_req(32'hE000_0000 + 32'(4 * i));
            expect_id(s1_dat[i], 32'hE000_0000 + 32'(4 * i), 5'b0);
            tick();
        end
        idle();
        tick();
        tick();

        // completion during a three-cycle stall is held and delivered after it
        do_reset();
        if_stall = 1'b1;
        ibus_ack = 1'b1;
        ibus_dat = 32'h0000_ABCD;
        expect_req(32'hE000_0000);
        expect_id(32'h0000_ABCD, 32'hE000_0000, 5'b0);
        tick();
        idle();
        #1;
        chk("stall_req1", {31'b0, ibus_req}, 32'h0);
        chk("stall_id1", id_insn, 32'h0);
        tick();
        chk("stall_req2", {31'b0, ibus_req}, 32'h0);
        chk("stall_id2", id_insn, 32'h0);
        tick();
        if_stall = 1'b0;
        #1;
        chk("hold_req", {31'b0, ibus_req}, 32'h0);
        tick();
        chk("post_stall_req", {31'b0, ibus_req}, 32'h1);
        chk("post_stall_adr", ibus_adr, 32'hE000_0004);
        tick();

        // branch with an outstanding request: stale ack is dropped
        do_reset();
        ibus_ack = 1'b1;
        ibus_dat = 32'h55;
        expect_req(32'hE000_0000);
        expect_id(32'h55, 32'hE000_0000, 5'b0);
        tick();
        ibus_dat = 32'h66;
        expect_req(32'hE000_0004);
        expect_id(32'h66, 32'hE000_0004, 5'b0);
        tick();
        idle();
        br_redirect = 1'b1;
        br_target   = 32'h0000_0100;
        #1;
        chk("br_out_adr", ibus_adr, 32'hE000_0008);
        expect_req(32'hE000_0008);
        tick();
        idle();
        #1;
        chk("discard_req", {31'b0, ibus_req}, 32'h1);
        chk("discard_adr", ibus_adr, 32'hE000_0008);
        tick();
        ibus_ack = 1'b1;
        ibus_dat = 32'hDEAD_BEEF;
        tick();
        ibus_dat = 32'h77;
        #1;
        chk("br_tgt_adr", ibus_adr, 32'h0000_0100);
        expect_req(32'h0000_0100);
        expect_id(32'h77, 32'h0000_0100, 5'b0);
        tick();
        idle();
        tick();
        tick();

        // simultaneous redirects: exception wins, same-cycle ack dropped
        do_reset();
        ibus_ack     = 1'b1;
        ibus_dat     = 32'h99;
        br_redirect  = 1'b1;
        br_target    = 32'h0000_0200;
        exc_redirect = 1'b1;
        exc_target   = 32'hE000_0004;
        expect_req(32'hE000_0000);
        tick();
        idle();
        #1;
        chk("prio_req", {31'b0, ibus_req}, 32'h1);
        chk("prio_adr", ibus_adr, 32'hE000_0004);
        ibus_ack = 1'b1;
        ibus_dat = 32'h88;
        expect_req(32'hE000_0004);
        expect_id(32'h88, 32'hE000_0004, 5'b0);
        tick();
        idle();
        tick();
        tick();

        // itlb miss: no request, flagged no-op, halt until exception redirect
        do_reset();
        ibus_ack    = 1'b1;
        ibus_dat    = 32'h12;
        br_redirect = 1'b1;
        br_target   = 32'h0000_0400;
        expect_req(32'hE000_0000);
        tick();
        idle();
        #1;
        chk("umiss_adr", ibus_adr, 32'h0000_0400);
        itlb_umiss = 1'b1;
        #1;
        chk("umiss_req", {31'b0, ibus_req}, 32'h0);
        expect_id(32'h0, 32'h0000_0400, 5'b00100);
        tick();
        itlb_umiss = 1'b0;
        #1;
        chk("halt_req1", {31'b0, ibus_req}, 32'h0);
        tick();
        chk("halt_req2", {31'b0, ibus_req}, 32'h0);
        exc_redirect = 1'b1;
        exc_target   = 32'h0000_0800;
        tick();
        idle();
        #1;
        chk("exc_req", {31'b0, ibus_req}, 32'h1);
        chk("exc_adr", ibus_adr, 32'h0000_0800);
        ibus_ack = 1'b1;
        ibus_dat = 32'h34;
        expect_req(32'h0000_0800);
        expect_id(32'h34, 32'h0000_0800, 5'b0);
        tick();
        idle();
        tick();
        tick();

        // bus error halts; reset in the middle of a discard
        do_reset();
        ibus_ack    = 1'b1;
        ibus_dat    = 32'h13;
        br_redirect = 1'b1;
        br_target   = 32'h0000_0500;
        expect_req(32'hE000_0000);
        tick();
        idle();
        ibus_err = 1'b1;
        #1;
        chk("err_adr", ibus_adr, 32'h0000_0500);
        expect_req(32'h0000_0500);
        expect_id(32'h0, 32'h0000_0500, 5'b10000);
        tick();
        idle();
        #1;
        chk("err_halt_req", {31'b0, ibus_req}, 32'h0);
        tick();
        chk("err_halt_req2", {31'b0, ibus_req}, 32'h0);
        br_redirect = 1'b1;
        br_target   = 32'h0000_0600;
        tick();
        idle();
        #1;
        chk("b600_adr", ibus_adr, 32'h0000_0600);
        br_redirect = 1'b1;
        br_target   = 32'h0000_0700;
        tick();
        idle();
        #1;
        chk("disc2_adr", ibus_adr, 32'h0000_0600);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {31'b0, ibus_req}, 32'h0);
        chk_id_reset("mid_rst");
        rst = 1'b0;
        #1;
        chk("mid_rst_next_req", {31'b0, ibus_req}, 32'h1);
        chk("mid_rst_next_adr", ibus_adr, 32'hE000_0000);
        ibus_ack = 1'b1;
        ibus_dat = 32'hAB;
        expect_req(32'hE000_0000);
        expect_id(32'hAB, 32'hE000_0000, 5'b0);
        tick();
        idle();
        tick();
        tick();

        chk("req_queue_left", 32'(exp_req.size()), 32'h0);
        chk("id_queue_left", 32'(exp_id.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
